etc_tile_reduce: RTL and testbench
==================================

# etc_tile_reduce

Output-side reduction stage for the extended tensor core tile datapath. Consumes a stream of 4x4 partial-result tiles (one per K-step of a larger semiring matrix product) and folds them element-wise with the selected reduce operator (plus, min, max, or). Emits one final 4x4 tile per job over a valid/ready handshake. Sits between the 4x4 tile engine output and the result writeback path.

## Interface
- W, 16: element width in bits, unsigned.
- KMAX, 64: maximum K-steps per job.
- KW, $clog2(KMAX+1): width of the K-step count.

- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_valid  in  1  job descriptor valid.
- cfg_ready  out  1  block can accept a descriptor.
- cfg_op  in  2  reduce op: 00 plus, 01 min, 10 max, 11 or.
- cfg_ktiles  in  KW  number of partial tiles in the job.
- in_valid  in  1  partial tile valid.
- in_ready  out  1  block accepts partial tile.
- in_tile  in  [3:0][3:0][W-1:0]  partial tile, [row][col].
- out_valid  out  1  final tile valid.
- out_ready  in  1  downstream accepts final tile.
- out_tile  out  [3:0][3:0][W-1:0]  reduced tile.
- sat_flag  out  1  sticky per job: a saturating add clipped (0 when macro off).

## Operation
- FSM states: IDLE, ACCUM, DONE.
- IDLE: cfg_ready=1. On cfg_valid&cfg_ready, latch op and ktiles, clear count, clear sat_flag.
  - ktiles in 1..KMAX -> ACCUM.
  - ktiles=0 -> load acc with all zeros -> DONE (no input consumed).
  - ktiles>KMAX -> clamp to KMAX.
- ACCUM: in_ready=1. Each in handshake increments count.
  - First tile (count==0): acc <= in_tile, no combine and no identity value.
  - Later tiles: acc[i][j] <= reduce(acc[i][j], in_tile[i][j]).
  - Handshake with count==ktiles-1 -> DONE.
- DONE: out_valid=1, out_tile=acc, held stable until out_ready. On handshake -> IDLE.
- Reduce arithmetic, all unsigned W-bit:
  - plus: sum modulo 2^W.
  - min / max: unsigned compare; on equality either operand is correct (identical values).
  - or: bitwise OR.
- cfg_valid is ignored outside IDLE. in_valid is ignored outside ACCUM.

## Timing
- Reset values:
  - state=IDLE, so cfg_ready=1.
  - in_ready=0, out_valid=0, out_tile=0, sat_flag=0, count=0.
- cfg_ready, in_ready and out_valid are decoded from registered state only, with no input-to-output combinational path.
- Latency: out_valid rises the cycle after the final in handshake. For ktiles=0 it rises the cycle after the cfg handshake.
- Throughput: one partial tile per cycle in ACCUM.
- Gaps: one idle cycle between an out handshake and the next cfg acceptance.
- Minimum job cost is ktiles+2 cycles from cfg accept to out accept.
- in_valid gaps in ACCUM: acc and count hold.
- Backpressure in DONE: out_tile must not change while out_valid=1 and out_ready=0.
- Reset mid-job: all state returns to reset values immediately (asynchronous). The partial job is discarded and no output is produced.

## Configuration
- ETC_REDUCE_SAT_EN defined:
  - The plus reduce saturates at 2^W-1.
  - sat_flag sets on any clipped add and stays set until the next cfg accept.
- ETC_REDUCE_SAT_EN undefined:
  - The plus reduce wraps modulo 2^W.
  - sat_flag is tied to 0.
- min, max and or behave the same with or without the macro.

## Structure
- Shared package etc_pkg holds:
  - the tile_t typedef ([3:0][3:0][W-1:0] with W=16);
  - the reduce_op_e enum (RED_PLUS=2'b00, RED_MIN=2'b01, RED_MAX=2'b10, RED_OR=2'b11);
  - the state enum.
- Sub-module etc_reduce_elem: a combinational single-element combine (a, b, op -> y, sat). It is instantiated 16 times in a generate loop.

## Test plan
- Plus reduce: op=00, ktiles=3, all elements 1, 2, 3 in consecutive cycles -> all elements 6. out_valid rises the cycle after the third accept.
- Min and max reduce: ktiles=2, tiles 0x0005 then 0xFFFF.
  - op=01 gives all 0x0005.
  - op=10 gives all 0xFFFF, which confirms the unsigned compare.
- Or with stalls: op=11, ktiles=4, tiles 0x0001, 0x0002, 0x0004, 0x0008, with in_valid low for 2 cycles between tiles -> all 0x000F. count holds during the gaps.
- Overflow: op=00, ktiles=2, 0xFFF0 + 0x0020.
  - Macro on: 0xFFFF, sat_flag=1.
  - Macro off: 0x0010, sat_flag=0.
- ktiles=0 and backpressure:
  - ktiles=0 -> zero tile with no in handshake.
  - out_ready held low 5 cycles -> out_tile stable and cfg_ready=0 throughout.
- Reset mid-job: assert rst_n low after 2 of 4 tiles -> out_valid=0 and cfg_ready=1. A new job with ktiles=1, tile 0x1234 -> 0x1234, with no residue from the aborted job.

Source files
------------

// File: rtl/etc_pkg.sv
// Shared types for the extended tensor core tile reduce stage.
package etc_pkg;

  localparam int unsigned ETC_W = 16;

  typedef logic [3:0][3:0][ETC_W-1:0] tile_t;

  typedef enum logic [1:0] {
    RED_PLUS = 2'b00,
    RED_MIN  = 2'b01,
    RED_MAX  = 2'b10,
    RED_OR   = 2'b11
  } reduce_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_DONE
  } state_e;

endpackage

// File: rtl/etc_reduce_elem.sv
// Combinational single-element combine for the tile reduce stage.
// ETC_REDUCE_SAT_EN selects a saturating plus; otherwise plus wraps and sat is 0.
module etc_reduce_elem
  import etc_pkg::*;
#(
  parameter int unsigned W = ETC_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  reduce_op_e   op,
  output logic [W-1:0] y,
  output logic         sat
);

`ifdef ETC_REDUCE_SAT_EN
  logic [W:0] sum_w;
  assign sum_w = {1'b0, a} + {1'b0, b};
`endif

  always_comb begin
    y   = '0;
    sat = 1'b0;
    case (op)
      RED_PLUS: begin
`ifdef ETC_REDUCE_SAT_EN
        y   = sum_w[W] ? '1 : sum_w[W-1:0];
        sat = sum_w[W];
`else
        y   = a + b;
`endif
      end
      RED_MIN: y = (a < b) ? a : b;
      RED_MAX: y = (a > b) ? a : b;
      RED_OR:  y = a | b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/etc_tile_reduce.sv
// Folds a stream of 4x4 partial tiles with a selectable reduce op into one output tile per job.
// ETC_REDUCE_SAT_EN enables saturating plus and the sticky sat_flag.
module etc_tile_reduce
  import etc_pkg::*;
#(
  parameter int unsigned W    = ETC_W,
  parameter int unsigned KMAX = 64,
  parameter int unsigned KW   = $clog2(KMAX + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [1:0]                cfg_op,
  input  logic [KW-1:0]             cfg_ktiles,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [3:0][3:0][W-1:0]    in_tile,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [3:0][3:0][W-1:0]    out_tile,
  output logic                      sat_flag
);

  state_e                   state_q, state_d;
  reduce_op_e               op_q, op_d;
  logic [KW-1:0]            ktiles_q, ktiles_d;
  logic [KW-1:0]            count_q, count_d;
  logic [3:0][3:0][W-1:0]   acc_q, acc_d;
  logic                     sat_q, sat_d;

  logic [3:0][3:0][W-1:0]   red_y;
  logic [15:0]              red_sat;

  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      etc_reduce_elem #(.W(W)) u_elem (
        .a   (acc_q[r][c]),
        .b   (in_tile[r][c]),
        .op  (op_q),
        .y   (red_y[r][c]),
        .sat (red_sat[r*4+c])
      );
    end
  end

  assign cfg_ready = (state_q == ST_IDLE);
  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_DONE);
  assign out_tile  = acc_q;
  assign sat_flag  = sat_q;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    ktiles_d = ktiles_q;
    count_d  = count_q;
    acc_d    = acc_q;
    sat_d    = sat_q;
    case (state_q)
      ST_IDLE: begin
        if (cfg_valid) begin
          op_d     = reduce_op_e'(cfg_op);
          ktiles_d = (cfg_ktiles > KW'(KMAX)) ? KW'(KMAX) : cfg_ktiles;
          count_d  = '0;
          sat_d    = 1'b0;
          if (cfg_ktiles == '0) begin
            acc_d   = '0;
            state_d = ST_DONE;
          end else begin
            state_d = ST_ACCUM;
          end
        end
      end
      ST_ACCUM: begin
        if (in_valid) begin
          count_d = count_q + KW'(1);
          // First tile seeds the accumulator so no identity value is needed per op.
          if (count_q == '0) begin
            acc_d = in_tile;
          end else begin
            acc_d = red_y;
            sat_d = sat_q | (|red_sat);
          end
          if (count_q == ktiles_q - KW'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= RED_PLUS;
      ktiles_q <= '0;
      count_q  <= '0;
      acc_q    <= '0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      ktiles_q <= ktiles_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      sat_q    <= sat_d;
    end
  end

endmodule

// File: tb/tb_etc_tile_reduce.sv
// Self-checking bench for etc_tile_reduce against an element-wise reference fold.
module tb_etc_tile_reduce;
  import etc_pkg::*;

  localparam int W    = 16;
  localparam int KMAX = 64;
  localparam int KW   = 7;
  localparam int TMO  = 200;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [1:0]    cfg_op = 2'b00;
  logic [KW-1:0] cfg_ktiles = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  tile_t         in_tile = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  tile_t         out_tile;
  logic          sat_flag;

  int    n_cmp = 0;
  int    n_bad = 0;
  tile_t sent[$];

  always #5 clk = ~clk;

  etc_tile_reduce #(.W(W), .KMAX(KMAX), .KW(KW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_op     (cfg_op),
    .cfg_ktiles (cfg_ktiles),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_tile    (in_tile),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_tile   (out_tile),
    .sat_flag   (sat_flag)
  );

  function automatic tile_t fill(input logic [15:0] v);
    tile_t t;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) t[r][c] = v;
    return t;
  endfunction

  function automatic tile_t rnd_tile();
    tile_t t;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        t[r][c] = ($urandom_range(0, 2) == 0) ? 16'(32'hFF00 + $urandom_range(0, 255))
                                              : 16'($urandom);
    return t;
  endfunction

  // Reference: fold all tiles sent in the job, using integer arithmetic.
  function automatic void model(input logic [1:0] op, output tile_t exp, output bit s);
    int unsigned a, b, t;
    exp = '0;
    s   = 1'b0;
    for (int k = 0; k < sent.size(); k++) begin
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          if (k == 0) begin
            exp[r][c] = sent[0][r][c];
          end else begin
            a = exp[r][c];
            b = sent[k][r][c];
            case (op)
              2'b00: begin
                t = a + b;
                if (t > 32'hFFFF) begin
`ifdef ETC_REDUCE_SAT_EN
                  t = 32'hFFFF;
                  s = 1'b1;
`else
                  t = t - 32'h10000;
`endif
                end
              end
              2'b01:   t = (a < b) ? a : b;
              2'b10:   t = (a > b) ? a : b;
              default: t = a | b;
            endcase
            exp[r][c] = 16'(t);
          end
        end
      end
    end
  endfunction

  task automatic start_job(input logic [1:0] op, input int k);
    int n = 0;
    cfg_op = op;
    cfg_ktiles = KW'(k);
    cfg_valid = 1'b1;
    while (!cfg_ready && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (!cfg_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL cfg_timeout: cfg_ready=%b required 1", cfg_ready);
    end
    @(posedge clk);
    @(negedge clk);
    cfg_valid = 1'b0;
    sent.delete();
  endtask

  task automatic feed(input tile_t t, input int gap);
    int n = 0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_tile = t;
    while (!in_ready && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL in_timeout: in_ready=%b required 1", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    sent.push_back(t);
  endtask

  task automatic collect(output tile_t t, output bit s);
    int n = 0;
    out_ready = 1'b1;
    while (!out_valid && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      n_cmp++; n_bad++;
      $display("FAIL out_timeout: out_valid=%b required 1", out_valid);
    end
    t = out_tile;
    s = sat_flag;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({cfg_ready, in_ready, out_valid, sat_flag} !== 4'b1000) begin
      n_bad++;
      $display("FAIL reset_ctrl: got rdy/in/ov/sat=%b required 1000",
               {cfg_ready, in_ready, out_valid, sat_flag});
    end
    n_cmp++;
    if (out_tile !== '0) begin
      n_bad++;
      $display("FAIL reset_tile: got %h required 0", out_tile);
    end
  endtask

  task automatic test_plus();
    tile_t exp, got;
    bit es, gs;
    start_job(2'b00, 3);
    feed(fill(16'd1), 0);
    feed(fill(16'd2), 0);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL plus_early_valid: got %b required 0", out_valid);
    end
    feed(fill(16'd3), 0);
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL plus_latency: out_valid=%b required 1", out_valid);
    end
    model(2'b00, exp, es);
    collect(got, gs);
    n_cmp++;
    if (got !== fill(16'd6) || got !== exp) begin
      n_bad++;
      $display("FAIL plus_tile: got %h required %h", got, exp);
    end
  endtask

  task automatic test_minmax();
    tile_t exp, got;
    bit es, gs;
    for (int op = 1; op <= 2; op++) begin
      start_job(2'(op), 2);
      feed(fill(16'h0005), 0);
      feed(fill(16'hFFFF), 0);
      model(2'(op), exp, es);
      collect(got, gs);
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL minmax_op%0d: got %h required %h", op, got, exp);
      end
    end
  endtask

  task automatic test_or_stalls();
    tile_t exp, got;
    bit es, gs;
    logic [15:0] v;
    start_job(2'b11, 4);
    feed(fill(16'h0001), 0);
    for (int i = 1; i < 4; i++) begin
      for (int g = 0; g < 2; g++) begin
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
          n_bad++;
          $display("FAIL or_gap: in_ready/out_valid=%b%b required 10", in_ready, out_valid);
        end
      end
      v = 16'(1 << i);
      feed(fill(v), 0);
    end
    model(2'b11, exp, es);
    collect(got, gs);
    n_cmp++;
    if (got !== exp || got !== fill(16'h000F)) begin
      n_bad++;
      $display("FAIL or_tile: got %h required %h", got, exp);
    end
  endtask

  task automatic test_overflow();
    tile_t exp, got;
    bit es, gs;
    start_job(2'b00, 2);
    feed(fill(16'hFFF0), 0);
    feed(fill(16'h0020), 0);
    model(2'b00, exp, es);
    collect(got, gs);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL ovf_tile: got %h required %h", got, exp);
    end
    n_cmp++;
    if (gs !== es) begin
      n_bad++;
      $display("FAIL ovf_sat: got %b required %b", gs, es);
    end
  endtask

  task automatic test_zero_backpressure();
    tile_t first, got;
    bit gs;
    start_job(2'($urandom_range(0, 3)), 0);
    n_cmp++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_latency: out_valid/in_ready=%b%b required 10", out_valid, in_ready);
    end
    first = out_tile;
    n_cmp++;
    if (first !== '0) begin
      n_bad++;
      $display("FAIL zero_tile: got %h required 0", first);
    end
    repeat (5) begin
      @(negedge clk);
      n_cmp++;
      if (out_tile !== first || cfg_ready !== 1'b0 || out_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL bp_hold: tile=%h rdy=%b ov=%b required tile %h rdy 0 ov 1",
                 out_tile, cfg_ready, out_valid, first);
      end
    end
    collect(got, gs);
    n_cmp++;
    if (cfg_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL post_out_idle: cfg_ready=%b required 1", cfg_ready);
    end
  endtask

  task automatic test_clamp();
    tile_t exp, got;
    bit es, gs;
    start_job(2'b00, 100);
    for (int i = 0; i < KMAX - 1; i++) feed(fill(16'd1), 0);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL clamp_early: out_valid=%b required 0", out_valid);
    end
    feed(fill(16'd1), 0);
    n_cmp++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL clamp_done: out_valid/in_ready=%b%b required 10", out_valid, in_ready);
    end
    model(2'b00, exp, es);
    collect(got, gs);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL clamp_tile: got %h required %h", got, exp);
    end
  endtask

  task automatic test_reset_midjob();
    tile_t got;
    bit gs;
    start_job(2'b00, 4);
    feed(rnd_tile(), 0);
    feed(rnd_tile(), 0);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || cfg_ready !== 1'b1 || in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset: ov/rdy/in=%b%b%b required 010", out_valid, cfg_ready, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_job(2'b00, 1);
    feed(fill(16'h1234), 0);
    collect(got, gs);
    n_cmp++;
    if (got !== fill(16'h1234) || gs !== 1'b0) begin
      n_bad++;
      $display("FAIL post_reset_job: got %h sat %b required %h sat 0", got, gs, fill(16'h1234));
    end
  endtask

  task automatic test_random();
    tile_t exp, got;
    bit es, gs;
    logic [1:0] op;
    int k;
    for (int j = 0; j < 20; j++) begin
      op = 2'($urandom_range(0, 3));
      k = $urandom_range(0, 6);
      start_job(op, k);
      for (int i = 0; i < k; i++) feed(rnd_tile(), $urandom_range(0, 2));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      model(op, exp, es);
      collect(got, gs);
      n_cmp++;
      if (got !== exp || gs !== es) begin
        n_bad++;
        $display("FAIL rand_job%0d op%0d k%0d: got %h sat %b required %h sat %b",
                 j, op, k, got, gs, exp, es);
      end
    end
  endtask

  initial begin
    test_reset();
    test_plus();
    test_minmax();
    test_or_stalls();
    test_overflow();
    test_zero_backpressure();
    test_clamp();
    test_reset_midjob();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
